// File: rtl/debounce_pkg.sv
// Shared types for the button debouncer: FSM state encoding and glitch counter width.
package debounce_pkg;
  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} deb_state_t;
  localparam int GLITCH_W = 8;
endpackage

// File: rtl/sync_chain.sv
// Metastability synchronizer: SYNC_STAGES flops in series, cleared asynchronously.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stages <= '0;
    else       stages <= {stages[SYNC_STAGES-2:0], d};
  end

  assign q = stages[SYNC_STAGES-1];
endmodule

// File: rtl/button_debouncer.sv
// Debounces an asynchronous input into a clean level plus one-cycle rise/fall pulses.
// Optional saturating abort counter on glitch_count when DEBOUNCE_GLITCH_CNT_EN is defined.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                raw_in,
  output logic                level_out,
  output logic                rise_pulse,
  output logic                fall_pulse
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_count
`endif
);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  // Count value at which the next matching sample completes the window.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  deb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, rise_nxt, fall_nxt, abort;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (raw_in),
    .q     (s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE_LOW;
      cnt        <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      level_out  <= level_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level_out;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE_LOW: if (s) begin
        // A one-sample window accepts the change immediately.
        if (STABLE_CYCLES == 1) begin
          state_nxt = IDLE_HIGH;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
          abort     = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      IDLE_HIGH: if (!s) begin
        if (STABLE_CYCLES == 1) begin
          state_nxt = IDLE_LOW;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
          abort     = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                             glitch_count <= '0;
    else if (abort && glitch_count != '1)  glitch_count <= glitch_count + GLITCH_W'(1);
  end
`else
  logic unused_abort;
  assign unused_abort = abort;
`endif
endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench: directed vector table, reset corner sequences and random bouncing
// input checked against a sample-window reference model, for default and 1/3 configurations.
module tb_button_debouncer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic raw = 1'b0, raw2 = 1'b0;
  logic lvl, rise, fall, lvl2, rise2, fall2;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] gc, gc2;
`endif

  int errors = 0;
  int checks = 0;
  bit run = 1'b0;

  button_debouncer #(.STABLE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .raw_in(raw),
    .level_out(lvl), .rise_pulse(rise), .fall_pulse(fall)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_count(gc)
`endif
  );

  button_debouncer #(.STABLE_CYCLES(1), .SYNC_STAGES(3)) dut2 (
    .clock(clock), .reset(reset), .raw_in(raw2),
    .level_out(lvl2), .rise_pulse(rise2), .fall_pulse(fall2)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_count(gc2)
`endif
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the input reaches the decision point after `sync` clocks; the level
  // flips once the last `stab` samples all disagree with it. An abort is a sample equal to
  // the level right after a disagreeing one that did not complete a window.
  bit rq[2][$];
  bit sh[2][$];
  bit mlev[2], mrise[2], mfall[2];
  int mgl[2];

  function automatic void m_reset(input int id, input int sync, input int stab);
    rq[id].delete();
    repeat (sync) rq[id].push_back(1'b0);
    sh[id].delete();
    repeat (stab + 1) sh[id].push_back(1'b0);
    mlev[id] = 1'b0; mrise[id] = 1'b0; mfall[id] = 1'b0; mgl[id] = 0;
  endfunction

  function automatic void m_step(input int id, input bit r, input int stab);
    bit s, all;
    int n;
    s = rq[id].pop_front();
    rq[id].push_back(r);
    sh[id].push_back(s);
    void'(sh[id].pop_front());
    n = sh[id].size();
    mrise[id] = 1'b0; mfall[id] = 1'b0;
    all = 1'b1;
    for (int i = 0; i < stab; i++) if (sh[id][n-1-i] == mlev[id]) all = 1'b0;
    if (all) begin
      mlev[id] = ~mlev[id];
      if (mlev[id]) mrise[id] = 1'b1; else mfall[id] = 1'b1;
    end else if (s == mlev[id] && sh[id][n-2] != mlev[id] && mgl[id] < 255) begin
      mgl[id]++;
    end
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_reset(0, 2, 4);
      m_reset(1, 3, 1);
    end else begin
      m_step(0, raw, 4);
      m_step(1, raw2, 1);
    end
  end

  always @(negedge clock) begin
    if (run) begin
      chk("model_lvl",   lvl,   mlev[0]);
      chk("model_rise",  rise,  mrise[0]);
      chk("model_fall",  fall,  mfall[0]);
      chk("model2_lvl",  lvl2,  mlev[1]);
      chk("model2_rise", rise2, mrise[1]);
      chk("model2_fall", fall2, mfall[1]);
      chk("excl", int'(rise & fall), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      chk("model_glitch",  gc,  mgl[0]);
      chk("model2_glitch", gc2, mgl[1]);
`endif
    end
  end

  typedef struct { bit raw; bit lvl; bit rise; bit fall; } vec_t;
  vec_t tbl[30];

  initial begin
    int len1, len2;
    // Clean rise (edges 0-7), clean fall (8-14), three 2-cycle bounces (15-26), settle (27-29).
    for (int i = 0; i < 30; i++) begin
      if (i < 8)       tbl[i] = '{1'b1, i >= 5, i == 5, 1'b0};
      else if (i < 15) tbl[i] = '{1'b0, i < 13, 1'b0, i == 13};
      else if (i < 27) tbl[i] = '{((i - 15) % 4) < 2, 1'b0, 1'b0, 1'b0};
      else             tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b0};
    end

    reset = 1'b1;
    @(negedge clock);
    run = 1'b1;
    chk("reset_lvl", lvl, 0);
    chk("reset_rise", rise, 0);
    chk("reset_fall", fall, 0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    repeat (4) @(negedge clock);

    for (int i = 0; i < 30; i++) begin
      raw  = tbl[i].raw;
      raw2 = ((i / 4) % 2) == 1;
      @(negedge clock);
      chk($sformatf("tbl%0d_lvl", i),  lvl,  tbl[i].lvl);
      chk($sformatf("tbl%0d_rise", i), rise, tbl[i].rise);
      chk($sformatf("tbl%0d_fall", i), fall, tbl[i].fall);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("bounce_glitch", gc, 3);
`endif

    // Reset with raw held high clears outputs at once, then the rise replays at edge 5.
    raw = 1'b1; raw2 = 1'b0;
    repeat (10) @(negedge clock);
    chk("pre_reset_lvl", lvl, 1);
    #2 reset = 1'b1;
    #1 chk("async_lvl", lvl, 0);
    chk("async_rise", rise, 0);
    chk("async_fall", fall, 0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk($sformatf("rel%0d_lvl", i),  lvl,  int'(i >= 5));
      chk($sformatf("rel%0d_rise", i), rise, int'(i == 5));
    end

    // Reset in the middle of a high window (count at 2) aborts without pulse or glitch.
    raw = 1'b0;
    repeat (10) @(negedge clock);
    raw = 1'b1;
    repeat (4) @(negedge clock);
    #2 reset = 1'b1; raw = 1'b0;
    #1 chk("midwait_lvl", lvl, 0);
    @(negedge clock);
    #2 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk($sformatf("midwait%0d_rise", i), rise, 0);
      chk($sformatf("midwait%0d_lvl", i),  lvl,  0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      chk($sformatf("midwait%0d_glitch", i), gc, 0);
`endif
    end

    // Random bouncing runs with occasional resets, checked by the model.
    len1 = 1; len2 = 1;
    for (int c = 0; c < 2000; c++) begin
      if (--len1 == 0) begin raw  = ~raw;  len1 = $urandom_range(1, 7); end
      if (--len2 == 0) begin raw2 = ~raw2; len2 = $urandom_range(1, 4); end
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        @(negedge clock);
        #2 reset = 1'b0;
      end
      @(negedge clock);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
